// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared defaults, TX FSM state type and counter-width helper
package board_io_pkg;

  localparam int SW_WIDTH_DEF        = 16;
  localparam int LED_WIDTH_DEF       = 16;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 65536;
  localparam int BLINK_DIV_DEF       = 25000000;
  localparam int N_UART_DEF          = 2;
  localparam int IDLE_CYCLES_DEF     = 1024;

  typedef enum logic {
    LOCKED    = 1'b0,
    WAIT_IDLE = 1'b1
  } tx_state_e;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/board_io_sync_if.sv
// rtl/board_io_sync_if.sv - UART source-select bundle between the top and the TX switch
interface board_io_sync_if #(
  parameter int N_UART = 2,
  parameter int SELW   = 1
);
  logic [N_UART-1:0] tx_src;
  logic [SELW-1:0]   sel_req;
  logic              tx_out;
  logic [SELW-1:0]   sel_act;

  modport master (output tx_src, output sel_req, input tx_out, input sel_act);
  modport slave  (input tx_src, input sel_req, output tx_out, output sel_act);
endinterface

// File: rtl/board_io_debounce.sv
// rtl/board_io_debounce.sv - one switch bit: synchroniser, debounce counter, edge pulses
module board_io_debounce
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, fall_q;
  logic                   synced, accept;

  assign synced = sync_q[SYNC_STAGES-1];

  // Any cycle matching the accepted value restarts the count, so bounces never leak through.
  always_comb begin
    cnt_d  = '0;
    db_d   = db_q;
    accept = 1'b0;
    if (synced != db_q) begin
      if (cnt_q == CNT_LAST) begin
        accept = 1'b1;
        db_d   = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= accept & synced;
      fall_q <= accept & ~synced;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/board_io_uart.sv
// rtl/board_io_uart.sv - glitch-free UART TX source switch, changes source only on a shared idle window
module board_io_uart
  import board_io_pkg::*;
#(
  parameter int N_UART      = N_UART_DEF,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int SELW        = cnt_w(N_UART)
) (
  input  logic               clk,
  input  logic               rstn,
  board_io_sync_if.slave     bus
);

  localparam int             ICW       = cnt_w(IDLE_CYCLES);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_CYCLES - 1);

  tx_state_e       state_q;
  logic [SELW-1:0] sel_q, req_q;
  logic [ICW-1:0]  idle_q;
  logic            tx_q;
  logic            req_valid, both_high;

  assign req_valid = (bus.sel_req != sel_q) && (32'(bus.sel_req) < N_UART);
  assign both_high = bus.tx_src[sel_q] & bus.tx_src[bus.sel_req];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LOCKED;
      sel_q   <= '0;
      req_q   <= '0;
      idle_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      tx_q <= bus.tx_src[sel_q];
      case (state_q)
        LOCKED: begin
          if (req_valid) begin
            state_q <= WAIT_IDLE;
            req_q   <= bus.sel_req;
            idle_q  <= '0;
          end
        end
        WAIT_IDLE: begin
          if (!req_valid) begin
            state_q <= LOCKED;
            idle_q  <= '0;
          end else if (bus.sel_req != req_q) begin
            req_q  <= bus.sel_req;
            idle_q <= '0;
          end else if (!both_high) begin
            idle_q <= '0;
          end else if (idle_q == IDLE_LAST) begin
            sel_q   <= req_q;
            state_q <= LOCKED;
            idle_q  <= '0;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        default: state_q <= LOCKED;
      endcase
    end
  end

  assign bus.tx_out  = tx_q;
  assign bus.sel_act = sel_q;

endmodule

// File: rtl/board_io_sync.sv
// rtl/board_io_sync.sv - board I/O: debounced switches with IRQ, blinking LEDs, UART TX source select
module board_io_sync
  import board_io_pkg::*;
#(
  parameter int SW_WIDTH        = SW_WIDTH_DEF,
  parameter int LED_WIDTH       = LED_WIDTH_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BLINK_DIV       = BLINK_DIV_DEF,
  parameter int N_UART          = N_UART_DEF,
  parameter int IDLE_CYCLES     = IDLE_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [SW_WIDTH-1:0]        i_sw,
  output logic [SW_WIDTH-1:0]        o_sw_db,
  output logic [SW_WIDTH-1:0]        o_sw_rise,
  output logic [SW_WIDTH-1:0]        o_sw_fall,
  input  logic [SW_WIDTH-1:0]        i_irq_mask,
  input  logic [SW_WIDTH-1:0]        i_irq_clr,
  output logic [SW_WIDTH-1:0]        o_irq_pend,
  output logic                       o_irq,
  input  logic [LED_WIDTH-1:0]       i_led,
  input  logic [LED_WIDTH-1:0]       i_led_blink,
  output logic [LED_WIDTH-1:0]       o_led,
  input  logic [N_UART-1:0]          i_uart_tx,
  input  logic [cnt_w(N_UART)-1:0]   i_uart_sel,
  output logic                       o_uart_tx,
  output logic [cnt_w(N_UART)-1:0]   o_uart_sel
);

  localparam int             SELW       = cnt_w(N_UART);
  localparam int             BCW        = cnt_w(BLINK_DIV);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

  logic [SW_WIDTH-1:0]  pend_q, pend_d;
  logic                 irq_q;
  logic [BCW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q;
  logic [LED_WIDTH-1:0] led_s1_q, led_q;

  for (genvar n = 0; n < SW_WIDTH; n++) begin : g_sw
    board_io_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rstn   (rstn),
      .sw_i   (i_sw[n]),
      .db_o   (o_sw_db[n]),
      .rise_o (o_sw_rise[n]),
      .fall_o (o_sw_fall[n])
    );
  end

  // Set wins over clear so an edge arriving with a clear is never lost.
  assign pend_d      = (pend_q & ~i_irq_clr) | o_sw_rise | o_sw_fall;
  assign blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q        <= '0;
      irq_q         <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      led_s1_q      <= '0;
      led_q         <= '0;
    end else begin
      pend_q        <= pend_d;
      irq_q         <= |(pend_q & i_irq_mask);
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_q ^ (blink_cnt_q == BLINK_LAST);
      led_s1_q      <= i_led & ({LED_WIDTH{blink_phase_q}} | ~i_led_blink);
      led_q         <= led_s1_q;
    end
  end

  assign o_irq_pend = pend_q;
  assign o_irq      = irq_q;
  assign o_led      = led_q;

  board_io_sync_if #(.N_UART(N_UART), .SELW(SELW)) uart_bus ();

  assign uart_bus.tx_src  = i_uart_tx;
  assign uart_bus.sel_req = i_uart_sel;
  assign o_uart_tx        = uart_bus.tx_out;
  assign o_uart_sel       = uart_bus.sel_act;

  board_io_uart #(
    .N_UART      (N_UART),
    .IDLE_CYCLES (IDLE_CYCLES),
    .SELW        (SELW)
  ) u_uart (
    .clk  (clk),
    .rstn (rstn),
    .bus  (uart_bus.slave)
  );

endmodule

// File: tb/tb_board_io_sync.sv
// tb/tb_board_io_sync.sv - directed self-checking bench for board_io_sync
module tb_board_io_sync;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] i_sw, i_irq_mask, i_irq_clr, i_led, i_led_blink;
  logic [15:0] o_sw_db, o_sw_rise, o_sw_fall, o_irq_pend, o_led;
  logic        o_irq, o_uart_tx;
  logic [1:0]  i_uart_tx;
  logic        i_uart_sel, o_uart_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  board_io_sync #(
    .SW_WIDTH(16), .LED_WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .BLINK_DIV(3), .N_UART(2), .IDLE_CYCLES(5)
  ) dut (
    .clk(clk), .rstn(rstn), .i_sw(i_sw), .o_sw_db(o_sw_db),
    .o_sw_rise(o_sw_rise), .o_sw_fall(o_sw_fall),
    .i_irq_mask(i_irq_mask), .i_irq_clr(i_irq_clr),
    .o_irq_pend(o_irq_pend), .o_irq(o_irq),
    .i_led(i_led), .i_led_blink(i_led_blink), .o_led(o_led),
    .i_uart_tx(i_uart_tx), .i_uart_sel(i_uart_sel),
    .o_uart_tx(o_uart_tx), .o_uart_sel(o_uart_sel)
  );

  task automatic test_reset();
    rstn = 1'b0; i_sw = '0; i_irq_mask = '0; i_irq_clr = '0;
    i_led = '0; i_led_blink = '0; i_uart_tx = 2'b11; i_uart_sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_sw_db, o_sw_rise, o_sw_fall, o_irq_pend, o_led} !== 80'd0) begin
      failures++; $display("FAIL reset_vectors got=%h want=0", {o_sw_db, o_sw_rise, o_sw_fall, o_irq_pend, o_led});
    end
    checks++;
    if ({o_irq, o_uart_sel, o_uart_tx} !== 3'b001) begin
      failures++; $display("FAIL reset_scalars got=%b want=001", {o_irq, o_uart_sel, o_uart_tx});
    end
    rstn = 1'b1;
  endtask

  task automatic test_debounce();
    @(negedge clk); i_sw[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 5) begin
        checks++;
        if (o_sw_db[0] !== 1'b0) begin failures++; $display("FAIL db_early got=%b want=0", o_sw_db[0]); end
      end
    end
    checks++;
    if ({o_sw_db[0], o_sw_rise[0]} !== 2'b11) begin
      failures++; $display("FAIL db_accept db_rise=%b want=11", {o_sw_db[0], o_sw_rise[0]});
    end
    @(negedge clk);
    checks++;
    if ({o_sw_rise[0], o_irq_pend[0]} !== 2'b01) begin
      failures++; $display("FAIL rise_once rise_pend=%b want=01", {o_sw_rise[0], o_irq_pend[0]});
    end
  endtask

  task automatic test_glitch();
    logic bad;
    bad = 1'b0;
    i_irq_mask = 16'h0008;
    @(negedge clk); i_sw[3] = 1'b1;
    repeat (3) @(negedge clk);
    i_sw[3] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bad = bad | o_sw_db[3] | o_sw_rise[3] | o_sw_fall[3] | o_irq_pend[3] | o_irq;
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL glitch_reject got=%b want=0", bad); end
  endtask

  task automatic test_irq_collision();
    logic seen;
    i_irq_mask = 16'h0001;
    repeat (2) @(negedge clk);
    checks++;
    if (o_irq !== 1'b1) begin failures++; $display("FAIL irq_masked_on got=%b want=1", o_irq); end
    i_irq_mask = 16'h0000;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_irq, o_irq_pend[0]} !== 2'b01) begin
      failures++; $display("FAIL mask_keeps_pend irq_pend=%b want=01", {o_irq, o_irq_pend[0]});
    end
    i_irq_mask = 16'h0001;
    i_sw[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = o_sw_fall[0];
    end
    checks++;
    if (seen !== 1'b1) begin failures++; $display("FAIL fall_pulse got=%b want=1", seen); end
    i_irq_clr = 16'h0001;
    @(negedge clk); i_irq_clr = '0;
    checks++;
    if (o_irq_pend[0] !== 1'b1) begin failures++; $display("FAIL set_beats_clr got=%b want=1", o_irq_pend[0]); end
    @(negedge clk);
    checks++;
    if (o_irq !== 1'b1) begin failures++; $display("FAIL irq_after_collision got=%b want=1", o_irq); end
    i_irq_clr = 16'h0001;
    @(negedge clk); i_irq_clr = '0;
    checks++;
    if (o_irq_pend[0] !== 1'b0) begin failures++; $display("FAIL clr_alone got=%b want=0", o_irq_pend[0]); end
    @(negedge clk);
    checks++;
    if (o_irq !== 1'b0) begin failures++; $display("FAIL irq_after_clr got=%b want=0", o_irq); end
  endtask

  task automatic test_led_blink();
    logic [7:0] prev, first, exp_lo;
    logic       found;
    i_led = 16'hFFFF; i_led_blink = 16'h00FF;
    repeat (3) @(negedge clk);
    prev = o_led[7:0]; found = 1'b0; first = '0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (o_led[7:0] !== prev) begin found = 1'b1; first = o_led[7:0]; end
    end
    checks++;
    if (found !== 1'b1 || !(first == 8'h00 || first == 8'hFF)) begin
      failures++; $display("FAIL led_toggle_seen found=%b low=%h want=1 and 00/FF", found, first);
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_lo = (((k / 3) % 2) == 1) ? ~first : first;
      checks++;
      if (o_led !== {8'hFF, exp_lo}) begin
        failures++; $display("FAIL led_pattern k=%0d got=%h want=%h", k, o_led, {8'hFF, exp_lo});
      end
    end
  endtask

  task automatic test_uart_switch();
    logic bad;
    bad = 1'b0;
    @(negedge clk); i_uart_sel = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bad = bad | (o_uart_sel !== 1'b0);
      i_uart_tx = {1'b1, (k % 4) != 3};
    end
    @(negedge clk);
    bad = bad | (o_uart_sel !== 1'b0);
    i_uart_tx = 2'b11;
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL uart_hold_busy got=%b want=0", bad); end
    repeat (4) @(negedge clk);
    checks++;
    if (o_uart_sel !== 1'b0) begin failures++; $display("FAIL uart_idle4 got=%b want=0", o_uart_sel); end
    @(negedge clk);
    checks++;
    if (o_uart_sel !== 1'b1) begin failures++; $display("FAIL uart_idle5 got=%b want=1", o_uart_sel); end
    i_uart_tx = 2'b01;
    @(negedge clk);
    checks++;
    if (o_uart_tx !== 1'b0) begin failures++; $display("FAIL uart_mux_src1_low got=%b want=0", o_uart_tx); end
    i_uart_tx = 2'b10;
    @(negedge clk);
    checks++;
    if (o_uart_tx !== 1'b1) begin failures++; $display("FAIL uart_mux_src1_high got=%b want=1", o_uart_tx); end
  endtask

  task automatic test_reset_mid();
    logic bad;
    bad = 1'b0;
    i_uart_tx = 2'b11; i_uart_sel = 1'b0; i_sw[5] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_uart_sel !== 1'b1) begin failures++; $display("FAIL pre_reset_sel got=%b want=1", o_uart_sel); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({o_uart_sel, o_uart_tx, o_irq} !== 3'b010 || {o_sw_rise, o_sw_fall, o_sw_db, o_irq_pend, o_led} !== 80'd0) begin
      failures++; $display("FAIL async_reset sel_tx_irq=%b vec=%h want=010 and 0",
                           {o_uart_sel, o_uart_tx, o_irq}, {o_sw_rise, o_sw_fall, o_sw_db, o_irq_pend, o_led});
    end
    i_sw = '0; i_led = '0;
    @(negedge clk); rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bad = bad | (|o_sw_rise) | (|o_sw_fall) | (|o_irq_pend) | o_uart_sel;
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL post_reset_quiet got=%b want=0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_irq_collision();
    test_led_blink();
    test_uart_switch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_io_sync.md
BOARD_IO_SYNC -- requirements
Module: board_io_sync

Interface
REQ-001 SHALL have parameter SW_WIDTH, default 16: number of switch inputs.
REQ-002 SHALL have parameter LED_WIDTH, default 16: number of LED outputs.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, min 2: synchroniser flop depth.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 65536, min 1: stable cycles before a switch change is accepted.
REQ-005 SHALL have parameter BLINK_DIV, default 25000000, min 1: cycles per blink-phase toggle.
REQ-006 SHALL have parameter N_UART, default 2, min 1: number of UART TX sources.
REQ-007 SHALL have parameter IDLE_CYCLES, default 1024, min 1: consecutive idle-high cycles required before a TX switchover.
REQ-008 SHALL have port clk, input, 1: single clock for all logic.
REQ-009 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-010 SHALL have port i_sw, input, SW_WIDTH: raw asynchronous switches.
REQ-011 SHALL have port o_sw_db, output, SW_WIDTH: debounced switch state.
REQ-012 SHALL have ports o_sw_rise and o_sw_fall, output, SW_WIDTH: one-cycle pulses on debounced edges.
REQ-013 SHALL have ports i_irq_mask and i_irq_clr, input, SW_WIDTH: interrupt enable, and write-1-to-clear pending.
REQ-014 SHALL have ports o_irq_pend, output, SW_WIDTH, and o_irq, output, 1: pending vector and combined interrupt.
REQ-015 SHALL have ports i_led and i_led_blink, input, LED_WIDTH: LED value and per-bit blink enable.
REQ-016 SHALL have port o_led, output, LED_WIDTH: registered LED drive.
REQ-017 SHALL have ports i_uart_tx, input, N_UART, and i_uart_sel, input, max(1,clog2(N_UART)): TX sources and requested source.
REQ-018 SHALL have ports o_uart_tx, output, 1, and o_uart_sel, output, same width as i_uart_sel: muxed TX and active source.

Function
REQ-019 Each i_sw bit SHALL pass through SYNC_STAGES flops before any use.
REQ-020 Per bit, the counter SHALL reset to 0 on any cycle where the synced value equals o_sw_db, else increment; o_sw_db SHALL take the synced value in the cycle the counter reaches DEBOUNCE_CYCLES-1, and the counter SHALL return to 0.
REQ-021 A bounce back to the stable value mid-count SHALL restart the count with no change on o_sw_db.
REQ-022 o_sw_rise/o_sw_fall SHALL assert for exactly the one cycle after o_sw_db changes 0->1 / 1->0.
REQ-023 o_irq_pend[n] SHALL set on o_sw_rise[n] or o_sw_fall[n] and clear on i_irq_clr[n]; simultaneous set and clear SHALL leave it set.
REQ-024 o_irq SHALL be the registered OR of o_irq_pend & i_irq_mask; masking SHALL not clear pending.
REQ-025 A blink counter SHALL toggle blink_phase every BLINK_DIV cycles and wrap to 0.
REQ-026 o_led[n] SHALL equal i_led[n] & (blink_phase | ~i_led_blink[n]) after a two-register pipeline (latency 2 cycles).
REQ-027 o_uart_tx SHALL be i_uart_tx[o_uart_sel], registered (latency 1 cycle).
REQ-028 TX FSM states SHALL be LOCKED, WAIT_IDLE: LOCKED->WAIT_IDLE when i_uart_sel != o_uart_sel and i_uart_sel < N_UART; WAIT_IDLE counts consecutive cycles where both current and requested sources are high, restarting on any low.
REQ-029 When the idle count reaches IDLE_CYCLES, o_uart_sel SHALL load the requested value and the FSM SHALL return to LOCKED.
REQ-030 A request change during WAIT_IDLE SHALL restart the idle count; a request equal to o_uart_sel or out of range SHALL return the FSM to LOCKED with o_uart_sel held.

Reset
REQ-031 On rstn low, sync flops, counters, o_sw_db, o_sw_rise, o_sw_fall, o_irq_pend, o_irq, o_led, blink_phase and o_uart_sel SHALL clear to 0; o_uart_tx SHALL be 1; FSM SHALL be LOCKED.
REQ-032 Reset asserted mid-debounce or mid-WAIT_IDLE SHALL abort the operation with no output pulse.

Structure
REQ-033 Parameter defaults, FSM state enum and counter-width helper functions SHALL live in package board_io_pkg.
REQ-034 Per-bit sync plus debounce plus edge detect SHALL be sub-module board_io_debounce, instantiated SW_WIDTH times.

Verification (bench params DEBOUNCE_CYCLES=4, BLINK_DIV=3, IDLE_CYCLES=5, N_UART=2)
REQ-035 i_sw[0] 0->1 held -> o_sw_db[0]=1 exactly SYNC_STAGES+4 cycles later, one o_sw_rise[0] pulse, o_irq_pend[0]=1.
REQ-036 i_sw[3] pulsed high 3 cycles then low -> o_sw_db[3] stays 0, no edge pulse, o_irq=0.
REQ-037 i_irq_mask=0x0001, pend[0] set, i_irq_clr=0x0001 same cycle as a new edge -> pend[0] stays 1, o_irq=1.
REQ-038 i_led=0xFFFF, i_led_blink=0x00FF -> o_led high byte constant 1s, low byte toggles every 3 cycles.
REQ-039 i_uart_sel=1 while i_uart_tx[0] toggles low every 4 cycles -> o_uart_sel stays 0; after both high 5 cycles -> o_uart_sel=1.
REQ-040 rstn low during WAIT_IDLE -> o_uart_sel=0, o_uart_tx=1, all pulses 0 immediately.
